// File: rtl/updown_counter_param.sv
// Parameterised up/down counter with parallel load, programmable step and
// either wrap-around or saturating behaviour at the 0 / MAX_VAL limits.
module updown_counter_param #(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
  parameter int          SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld_cnt,
  input  logic             updn_cnt,
  input  logic             count_enb,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] data_out,
  output logic             at_max,
  output logic             at_min,
  output logic             limit_evt
);

  localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MAX_P1 = MAX_W + {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ZERO_W = {(WIDTH+1){1'b0}};
  localparam logic [WIDTH-1:0] MAX_N  = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] data_out_r;
  logic             limit_evt_r;
  logic [WIDTH:0]   cur_s;
  logic [WIDTH:0]   s_s;
  logic [WIDTH:0]   ld_val_s;
  logic [WIDTH:0]   up_sum_s;
  logic [WIDTH:0]   dn_wrap_s;
  logic [WIDTH-1:0] next_data_s;
  logic             next_evt_s;

  function automatic logic [WIDTH:0] clamp_max(input logic [WIDTH:0] v);
    clamp_max = (v > MAX_W) ? MAX_W : v;
  endfunction

  // Next-state selection: load beats counting, counting beats hold.
  always_comb begin
    cur_s       = {1'b0, data_out_r};
    s_s         = clamp_max({1'b0, step});
    ld_val_s    = clamp_max({1'b0, data_in});
    up_sum_s    = cur_s + s_s;
    dn_wrap_s   = (cur_s + MAX_P1) - s_s;
    next_data_s = data_out_r;
    next_evt_s  = 1'b0;
    if (ld_cnt) begin
      next_data_s = WIDTH'(ld_val_s);
    end else if (count_enb && (s_s != ZERO_W)) begin
      if (updn_cnt) begin
        if (up_sum_s > MAX_W) begin
          next_evt_s  = 1'b1;
          next_data_s = (SATURATE != 0) ? MAX_N : WIDTH'(up_sum_s - MAX_P1);
        end else begin
          next_data_s = WIDTH'(up_sum_s);
        end
      end else begin
        if (s_s > cur_s) begin
          next_evt_s  = 1'b1;
          next_data_s = (SATURATE != 0) ? {WIDTH{1'b0}} : WIDTH'(dn_wrap_s);
        end else begin
          next_data_s = WIDTH'(cur_s - s_s);
        end
      end
    end else begin
      next_data_s = data_out_r;
    end
  end

  // Count and limit-event registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r  <= {WIDTH{1'b0}};
      limit_evt_r <= 1'b0;
    end else begin
      data_out_r  <= next_data_s;
      limit_evt_r <= next_evt_s;
    end
  end

  assign data_out  = data_out_r;
  assign limit_evt = limit_evt_r;
  assign at_max    = (data_out_r == MAX_N);
  assign at_min    = (data_out_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench: two WIDTH=4/MAX_VAL=9 counters (wrap, saturate) share one
// stimulus stream; a default-parameter counter gets its own stream.
module tb_updown_counter_param;

  typedef struct {
    int         inst;
    logic [7:0] d;
    logic       mx;
    logic       mn;
    logic       ev;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  logic       clk = 1'b0;
  logic       a_rst = 1'b0, a_ld = 1'b0, a_up = 1'b0, a_en = 1'b0;
  logic [3:0] a_din = 4'd0, a_step = 4'd0;
  logic [3:0] w_out, s_out;
  logic       w_mx, w_mn, w_ev, s_mx, s_mn, s_ev;

  logic       b_rst = 1'b0, b_ld = 1'b0, b_up = 1'b0, b_en = 1'b0;
  logic [7:0] b_din = 8'd0, b_step = 8'd0;
  logic [7:0] d_out;
  logic       d_mx, d_mn, d_ev;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(a_rst), .data_in(a_din), .ld_cnt(a_ld), .updn_cnt(a_up),
    .count_enb(a_en), .step(a_step), .data_out(w_out), .at_max(w_mx),
    .at_min(w_mn), .limit_evt(w_ev));

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u_sat (
    .clk(clk), .rst(a_rst), .data_in(a_din), .ld_cnt(a_ld), .updn_cnt(a_up),
    .count_enb(a_en), .step(a_step), .data_out(s_out), .at_max(s_mx),
    .at_min(s_mn), .limit_evt(s_ev));

  updown_counter_param u_def (
    .clk(clk), .rst(b_rst), .data_in(b_din), .ld_cnt(b_ld), .updn_cnt(b_up),
    .count_enb(b_en), .step(b_step), .data_out(d_out), .at_max(d_mx),
    .at_min(d_mn), .limit_evt(d_ev));

  task automatic push(input int inst, input logic [7:0] d, input logic [7:0] maxv,
                      input logic ev, input string nm);
    exp_t e;
    e.inst = inst; e.d = d; e.ev = ev; e.nm = nm;
    e.mx = (d == maxv);
    e.mn = (d == 8'd0);
    sb.push_back(e);
  endtask

  // One cycle on the shared 4-bit stream; expected (value, event) for wrap and saturate.
  task automatic drive_a(input logic r, input logic ld, input logic [3:0] din,
                         input logic up, input logic en, input logic [3:0] st,
                         input logic [3:0] ew, input logic vw,
                         input logic [3:0] es, input logic vs, input string nm);
    @(negedge clk);
    a_rst = r; a_ld = ld; a_din = din; a_up = up; a_en = en; a_step = st;
    push(0, {4'd0, ew}, 8'd9, vw, {nm, "/wrap"});
    push(1, {4'd0, es}, 8'd9, vs, {nm, "/sat"});
  endtask

  task automatic drive_b(input logic r, input logic ld, input logic [7:0] din,
                         input logic up, input logic en, input logic [7:0] st,
                         input logic [7:0] e, input logic v, input string nm);
    @(negedge clk);
    b_rst = r; b_ld = ld; b_din = din; b_up = up; b_en = en; b_step = st;
    push(2, e, 8'd255, v, {nm, "/def"});
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Monitor: every entry pushed before an edge describes the state after it.
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      logic [7:0] ad;
      logic       amx, amn, aev;
      e = sb.pop_front();
      case (e.inst)
        0:       begin ad = {4'd0, w_out}; amx = w_mx; amn = w_mn; aev = w_ev; end
        1:       begin ad = {4'd0, s_out}; amx = s_mx; amn = s_mn; aev = s_ev; end
        default: begin ad = d_out;         amx = d_mx; amn = d_mn; aev = d_ev; end
      endcase
      chk({e.nm, ".data_out"},  ad,          e.d);
      chk({e.nm, ".at_max"},    {7'd0, amx}, {7'd0, e.mx});
      chk({e.nm, ".at_min"},    {7'd0, amn}, {7'd0, e.mn});
      chk({e.nm, ".limit_evt"}, {7'd0, aev}, {7'd0, e.ev});
    end
  end

  initial begin
    //      rst   ld    din    up    en    step   wrap  ev    sat   ev
    drive_a(1'b1, 1'b1, 4'd5,  1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 4'd0, 1'b0, "rst_over_ld");
    drive_a(1'b0, 1'b1, 4'd7,  1'b0, 1'b0, 4'd0,  4'd7, 1'b0, 4'd7, 1'b0, "load7");
    drive_a(1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  4'd8, 1'b0, 4'd8, 1'b0, "up_to8");
    drive_a(1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  4'd9, 1'b0, 4'd9, 1'b0, "up_to9");
    drive_a(1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  4'd0, 1'b1, 4'd9, 1'b1, "up_limit");
    drive_a(1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  4'd1, 1'b0, 4'd9, 1'b1, "up_after");
    drive_a(1'b0, 1'b1, 4'd2,  1'b0, 1'b0, 4'd0,  4'd2, 1'b0, 4'd2, 1'b0, "load2");
    drive_a(1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd5,  4'd7, 1'b1, 4'd0, 1'b1, "dn_limit");
    drive_a(1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd5,  4'd2, 1'b0, 4'd0, 1'b1, "dn_again");
    drive_a(1'b0, 1'b1, 4'd14, 1'b0, 1'b0, 4'd0,  4'd9, 1'b0, 4'd9, 1'b0, "load_clamp");
    drive_a(1'b0, 1'b1, 4'd3,  1'b0, 1'b0, 4'd0,  4'd3, 1'b0, 4'd3, 1'b0, "load3");
    drive_a(1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd12, 4'd2, 1'b1, 4'd9, 1'b1, "step_clamp");
    drive_a(1'b0, 1'b1, 4'd4,  1'b1, 1'b1, 4'd3,  4'd4, 1'b0, 4'd4, 1'b0, "ld_over_en");
    drive_a(1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd3,  4'd4, 1'b0, 4'd4, 1'b0, "hold");
    drive_a(1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0,  4'd4, 1'b0, 4'd4, 1'b0, "step0");
    drive_a(1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd4,  4'd0, 1'b0, 4'd0, 1'b0, "dn_exact0");
    drive_a(1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd9,  4'd9, 1'b0, 4'd9, 1'b0, "up_exactmax");
    drive_a(1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  4'd0, 1'b0, 4'd0, 1'b0, "rst_over_en");
    drive_a(1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd1,  4'd0, 1'b0, 4'd0, 1'b0, "hold_after_rst");

    @(negedge clk);
    a_rst = 1'b0; a_ld = 1'b0; a_en = 1'b0;
    //      rst   ld    din     up    en    step     exp      ev
    drive_b(1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 8'd0,    8'd0,    1'b0, "reset");
    drive_b(1'b0, 1'b1, 8'd255, 1'b0, 1'b0, 8'd0,    8'd255,  1'b0, "load255");
    drive_b(1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 8'd1,    8'd0,    1'b1, "up_wrap");
    drive_b(1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 8'd1,    8'd255,  1'b1, "dn_wrap");
    drive_b(1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 8'd1,    8'd254,  1'b0, "dn_plain");
    drive_b(1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 8'd200,  8'd198,  1'b1, "up_bigstep");
    drive_b(1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 8'd200,  8'd198,  1'b0, "hold");

    @(negedge clk);
    b_en = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, required finished");
    $fatal(1, "timeout");
  end

endmodule
